// File: rtl/conf_sram2axi_pkg.sv
// -----------------------------------------------------------------------------
// conf_sram2axi_pkg
// Shared definitions for the uncached SRAM-style to AXI4 bridge:
//   - state_e        : bridge FSM states
//   - AXI_BURST_*    : AXI burst type encodings
//   - AXI_RESP_*     : AXI response encodings
//   - size_to_wstrb  : byte-count code + low address bits -> write strobes
// -----------------------------------------------------------------------------
package conf_sram2axi_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_AR  = 3'd1,
    RD_R   = 3'd2,
    WR_AWW = 3'd3,
    WR_B   = 3'd4
  } state_e;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Size codes above 2 fall through to a full-word strobe.
  function automatic logic [3:0] size_to_wstrb(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << addr_lo;
      2'd1:    strb = 4'b0011 << {addr_lo[1], 1'b0};
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/conf_sram2axi.sv
// -----------------------------------------------------------------------------
// conf_sram2axi
// Bridges a single-outstanding uncached SRAM-like request interface onto an
// AXI4 master with single-beat transfers (len 0, INCR).
//
// Parameters
//   AXI_ID            ID driven on arid/awid
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   conf_data_req/wr/size/addr/wdata   request side inputs
//   conf_data_rdata/addr_ok/data_ok    request side outputs
//   ar*, r*                       AXI4 read address / read data channels
//   aw*, w*, b*                   AXI4 write address / data / response channels
//   conf_data_err                 (CONF_AXI_ERR_EN only) error pulse with data_ok
//
// Build option
//   CONF_AXI_ERR_EN   adds conf_data_err, set when rresp/bresp has bit 1 high
//
// State        | meaning
// -------------+------------------------------------------------------------
// IDLE         | waiting for a request; addr_ok follows conf_data_req
// RD_AR        | arvalid held until arready
// RD_R         | rready held until rvalid; rdata captured
// WR_AWW       | awvalid/wvalid raised together, each dropped on own handshake
// WR_B         | bready held until bvalid
// -----------------------------------------------------------------------------
module conf_sram2axi
  import conf_sram2axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        conf_data_req,
  input  logic        conf_data_wr,
  input  logic [1:0]  conf_data_size,
  input  logic [31:0] conf_data_addr,
  input  logic [31:0] conf_data_wdata,
  output logic [31:0] conf_data_rdata,
  output logic        conf_data_addr_ok,
  output logic        conf_data_data_ok,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,

  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,

  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
`ifdef CONF_AXI_ERR_EN
  ,
  output logic        conf_data_err
`endif
);

  state_e      state_q, state_d;
  logic [1:0]  size_q,  size_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q,  w_done_d;
  logic        data_ok_q, data_ok_d;
  logic        accept;

`ifdef CONF_AXI_ERR_EN
  logic        err_q, err_d;
  logic        unused_resp;
  assign unused_resp = ^{rid, bid, rlast, rresp[0], bresp[0]};
`else
  logic        unused_resp;
  assign unused_resp = ^{rid, bid, rlast, rresp, bresp};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      size_q    <= 2'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      data_ok_q <= 1'b0;
`ifdef CONF_AXI_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      data_ok_q <= data_ok_d;
`ifdef CONF_AXI_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    data_ok_d = 1'b0;
    accept    = 1'b0;
`ifdef CONF_AXI_ERR_EN
    err_d     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (conf_data_req) begin
          accept    = 1'b1;
          // Size code 3 is folded into a word access at capture time so the
          // AXI size and strobe paths never see it.
          size_d    = (conf_data_size == 2'd3) ? 2'd2 : conf_data_size;
          addr_d    = conf_data_addr;
          wdata_d   = conf_data_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = conf_data_wr ? WR_AWW : RD_AR;
        end
      end

      RD_AR: begin
        if (arready) state_d = RD_R;
      end

      RD_R: begin
        if (rvalid) begin
          rdata_d   = rdata;
          data_ok_d = 1'b1;
`ifdef CONF_AXI_ERR_EN
          err_d     = rresp[1];
`endif
          state_d   = IDLE;
        end
      end

      WR_AWW: begin
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q  | wready;
        // Either channel may finish first or both may finish together.
        if ((aw_done_q | awready) && (w_done_q | wready)) state_d = WR_B;
      end

      WR_B: begin
        if (bvalid) begin
          data_ok_d = 1'b1;
`ifdef CONF_AXI_ERR_EN
          err_d     = bresp[1];
`endif
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // rst gating keeps addr_ok low even if a request is presented during reset.
  assign conf_data_addr_ok = accept & ~rst;
  assign conf_data_data_ok = data_ok_q;
  assign conf_data_rdata   = rdata_q;
`ifdef CONF_AXI_ERR_EN
  assign conf_data_err     = err_q;
`endif

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = AXI_BURST_INCR;
  assign arvalid = (state_q == RD_AR);
  assign rready  = (state_q == RD_R);

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, size_q};
  assign awburst = AXI_BURST_INCR;
  assign awvalid = (state_q == WR_AWW) && !aw_done_q;

  assign wdata   = wdata_q;
  assign wstrb   = size_to_wstrb(size_q, addr_q[1:0]);
  assign wlast   = 1'b1;
  assign wvalid  = (state_q == WR_AWW) && !w_done_q;

  assign bready  = (state_q == WR_B);

endmodule

// File: tb/tb_conf_sram2axi.sv
module tb_conf_sram2axi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        conf_data_req = 1'b0, conf_data_wr = 1'b0;
  logic [1:0]  conf_data_size = 2'd0;
  logic [31:0] conf_data_addr = 32'd0, conf_data_wdata = 32'd0;
  logic [31:0] conf_data_rdata;
  logic        conf_data_addr_ok, conf_data_data_ok;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, awvalid, wvalid, wlast, rready, bready;
  logic [3:0]  wstrb;
  logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [3:0]  rid = 4'd1, bid = 4'd1;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'b00, bresp = 2'b00;
`ifdef CONF_AXI_ERR_EN
  logic        conf_data_err;
`endif

  always #5 clk = ~clk;

  conf_sram2axi #(.AXI_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .conf_data_req(conf_data_req), .conf_data_wr(conf_data_wr),
    .conf_data_size(conf_data_size), .conf_data_addr(conf_data_addr),
    .conf_data_wdata(conf_data_wdata), .conf_data_rdata(conf_data_rdata),
    .conf_data_addr_ok(conf_data_addr_ok), .conf_data_data_ok(conf_data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef CONF_AXI_ERR_EN
    , .conf_data_err(conf_data_err)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Slave behaviour knobs
  int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [31:0] r_data_cfg = 32'd0;
  logic [1:0]  r_resp_cfg = 2'b00, b_resp_cfg = 2'b00;

  // Monitor state (updated on negedge, i.e. what the next rising edge will see)
  int cyc = 0;
  int n_addr_ok = 0, n_data_ok = 0, n_ar = 0, n_r = 0, n_aw = 0, n_w = 0, n_b = 0;
  int r_cyc = 0, b_cyc = 0, aw_cyc = 0, w_cyc = 0;
  int addr_ok_cyc[$];
  int dok_cyc[$];
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata, last_dok_rdata;
  logic [2:0]  cap_arsize, cap_awsize;
  logic [7:0]  cap_arlen, cap_awlen;
  logic [1:0]  cap_arburst, cap_awburst;
  logic [3:0]  cap_arid, cap_awid, cap_wstrb;
  logic        cap_wlast, last_err;

  always @(negedge clk) begin
    cyc++;
    if (conf_data_addr_ok) begin n_addr_ok++; addr_ok_cyc.push_back(cyc); end
    if (conf_data_data_ok) begin
      n_data_ok++; dok_cyc.push_back(cyc); last_dok_rdata = conf_data_rdata;
`ifdef CONF_AXI_ERR_EN
      last_err = conf_data_err;
`else
      last_err = 1'b0;
`endif
    end
    if (arvalid && arready) begin
      n_ar++; cap_araddr = araddr; cap_arsize = arsize; cap_arlen = arlen;
      cap_arburst = arburst; cap_arid = arid;
    end
    if (rvalid && rready) begin n_r++; r_cyc = cyc; end
    if (awvalid && awready) begin
      n_aw++; aw_cyc = cyc; cap_awaddr = awaddr; cap_awsize = awsize; cap_awlen = awlen;
      cap_awburst = awburst; cap_awid = awid;
    end
    if (wvalid && wready) begin
      n_w++; w_cyc = cyc; cap_wdata = wdata; cap_wstrb = wstrb; cap_wlast = wlast;
    end
    if (bvalid && bready) begin n_b++; b_cyc = cyc; end
  end

  // Read slave: arready after ar_delay cycles, then one rvalid beat after r_delay.
  initial forever begin
    @(posedge clk); #1;
    if (arvalid) begin
      repeat (ar_delay) begin @(posedge clk); #1; end
      arready = 1'b1;
      @(posedge clk); #1;
      arready = 1'b0;
      repeat (r_delay) begin @(posedge clk); #1; end
      rvalid = 1'b1; rlast = 1'b1; rdata = r_data_cfg; rresp = r_resp_cfg;
      @(posedge clk); #1;
      rvalid = 1'b0; rlast = 1'b0;
    end
  end

  // Write slave: independent awready / wready delays, bvalid after both.
  initial forever begin
    @(posedge clk); #1;
    if (awvalid || wvalid) begin
      fork
        begin
          repeat (aw_delay) begin @(posedge clk); #1; end
          awready = 1'b1; @(posedge clk); #1; awready = 1'b0;
        end
        begin
          repeat (w_delay) begin @(posedge clk); #1; end
          wready = 1'b1; @(posedge clk); #1; wready = 1'b0;
        end
      join
      repeat (b_delay) begin @(posedge clk); #1; end
      bvalid = 1'b1; bresp = b_resp_cfg;
      @(posedge clk); #1;
      bvalid = 1'b0;
    end
  end

  // Reference: strobe from byte count and byte lane, by plain arithmetic.
  function automatic logic [3:0] model_strb(input int sz, input logic [31:0] a);
    int lane;
    lane = int'(a % 4);
    if (sz == 3) sz = 2;
    if (sz == 0) return 4'(1 << lane);
    if (sz == 1) return 4'(3 << ((lane / 2) * 2));
    return 4'hF;
  endfunction

  // Issues one request, drops req after acceptance, waits for completion.
  task automatic drive_txn(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, output bit timed_out);
    int a0, d0;
    a0 = n_addr_ok; d0 = n_data_ok; timed_out = 1'b0;
    @(posedge clk); #1;
    conf_data_req = 1'b1; conf_data_wr = wr; conf_data_size = sz;
    conf_data_addr = a; conf_data_wdata = wd;
    for (int i = 0; i < 100; i++) begin @(negedge clk); #1; if (n_addr_ok != a0) break; end
    if (n_addr_ok == a0) timed_out = 1'b1;
    @(posedge clk); #1;
    conf_data_req = 1'b0;
    if (!timed_out) begin
      for (int i = 0; i < 200; i++) begin @(negedge clk); #1; if (n_data_ok != d0) break; end
      if (n_data_ok == d0) timed_out = 1'b1;
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  logic [31:0] exp_rdata = 32'd0;

  task automatic test_reset();
    conf_data_req = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin n_fail++; $display("FAIL reset_valids: got %b required 00000", {arvalid, rready, awvalid, wvalid, bready}); end
    n_checks++; if (conf_data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL reset_addr_ok: got %b required 0", conf_data_addr_ok); end
    n_checks++; if (conf_data_data_ok !== 1'b0) begin n_fail++; $display("FAIL reset_data_ok: got %b required 0", conf_data_data_ok); end
    n_checks++; if (conf_data_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h required 00000000", conf_data_rdata); end
`ifdef CONF_AXI_ERR_EN
    n_checks++; if (conf_data_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", conf_data_err); end
`endif
    conf_data_req = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read();
    bit to; int a0, d0, ar0;
    a0 = n_addr_ok; d0 = n_data_ok; ar0 = n_ar;
    ar_delay = 3; r_delay = 1; r_data_cfg = 32'hDEAD_BEEF; r_resp_cfg = 2'b00;
    drive_txn(1'b0, 2'd2, 32'h1FD0_F000, 32'h0, to);
    exp_rdata = 32'hDEAD_BEEF;
    n_checks++; if (to) begin n_fail++; $display("FAIL read_timeout: got timeout required completion"); end
    n_checks++; if (n_addr_ok - a0 != 1) begin n_fail++; $display("FAIL read_addr_ok_count: got %0d required 1", n_addr_ok - a0); end
    n_checks++; if (n_data_ok - d0 != 1) begin n_fail++; $display("FAIL read_data_ok_count: got %0d required 1", n_data_ok - d0); end
    n_checks++; if (n_ar - ar0 != 1) begin n_fail++; $display("FAIL read_ar_beats: got %0d required 1", n_ar - ar0); end
    n_checks++; if (cap_araddr !== 32'h1FD0_F000) begin n_fail++; $display("FAIL read_araddr: got %h required 1fd0f000", cap_araddr); end
    n_checks++; if (cap_arsize !== 3'd2) begin n_fail++; $display("FAIL read_arsize: got %0d required 2", cap_arsize); end
    n_checks++; if ({cap_arlen, cap_arburst, cap_arid} !== {8'd0, 2'b01, 4'd1}) begin n_fail++; $display("FAIL read_ar_fixed: got len %0d burst %b id %0d required 0 01 1", cap_arlen, cap_arburst, cap_arid); end
    n_checks++; if (last_dok_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_rdata: got %h required deadbeef", last_dok_rdata); end
    n_checks++; if (dok_cyc[$] != r_cyc + 1) begin n_fail++; $display("FAIL read_dok_timing: got cycle %0d required %0d", dok_cyc[$], r_cyc + 1); end
  endtask

  task automatic test_byte_write();
    bit to; int aw0, w0;
    aw0 = n_aw; w0 = n_w;
    aw_delay = 1; w_delay = 1; b_delay = 2; b_resp_cfg = 2'b00;
    drive_txn(1'b1, 2'd0, 32'h1FD0_F003, 32'h0000_00AA, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL bytew_timeout: got timeout required completion"); end
    n_checks++; if (cap_wstrb !== 4'b1000) begin n_fail++; $display("FAIL bytew_wstrb: got %b required 1000", cap_wstrb); end
    n_checks++; if ({cap_awlen, cap_wlast, cap_awburst} !== {8'd0, 1'b1, 2'b01}) begin n_fail++; $display("FAIL bytew_len_last: got len %0d last %b burst %b required 0 1 01", cap_awlen, cap_wlast, cap_awburst); end
    n_checks++; if (cap_wdata !== 32'h0000_00AA || cap_awaddr !== 32'h1FD0_F003) begin n_fail++; $display("FAIL bytew_data_addr: got %h @%h required 000000aa @1fd0f003", cap_wdata, cap_awaddr); end
    n_checks++; if (dok_cyc[$] != b_cyc + 1) begin n_fail++; $display("FAIL bytew_dok_timing: got cycle %0d required %0d", dok_cyc[$], b_cyc + 1); end
    n_checks++; if (n_aw - aw0 != 1 || n_w - w0 != 1) begin n_fail++; $display("FAIL bytew_beats: got aw %0d w %0d required 1 1", n_aw - aw0, n_w - w0); end
    n_checks++; if (conf_data_rdata !== exp_rdata) begin n_fail++; $display("FAIL bytew_rdata_hold: got %h required %h", conf_data_rdata, exp_rdata); end
  endtask

  task automatic test_write_order();
    bit to; int aw0, w0, b0;
    for (int k = 0; k < 2; k++) begin
      aw0 = n_aw; w0 = n_w; b0 = n_b;
      aw_delay = (k == 0) ? 2 : 1; w_delay = (k == 0) ? 0 : 1; b_delay = 0;
      drive_txn(1'b1, 2'd1, 32'h0000_1002 + k, 32'h1234_5678 + k, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL wr_order%0d_timeout: got timeout required completion", k); end
      n_checks++; if (n_aw - aw0 != 1 || n_w - w0 != 1 || n_b - b0 != 1) begin n_fail++; $display("FAIL wr_order%0d_beats: got aw %0d w %0d b %0d required 1 1 1", k, n_aw - aw0, n_w - w0, n_b - b0); end
      n_checks++; if (aw_cyc - w_cyc != ((k == 0) ? 2 : 0)) begin n_fail++; $display("FAIL wr_order%0d_skew: got %0d required %0d", k, aw_cyc - w_cyc, (k == 0) ? 2 : 0); end
      n_checks++; if (cap_wstrb !== 4'b1100) begin n_fail++; $display("FAIL wr_order%0d_wstrb: got %b required 1100", k, cap_wstrb); end
    end
  endtask

  task automatic test_back_to_back();
    int a0, d0, ar0, aw0, w0;
    bit to;
    logic [1:0] kwr;
    a0 = n_addr_ok; d0 = n_data_ok; ar0 = n_ar; aw0 = n_aw; w0 = n_w; to = 1'b0;
    ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;
    r_data_cfg = 32'hCAFE_0001;
    kwr = 2'b01;  // wr flag for txn 0,1,2 = 0,1,0
    @(posedge clk); #1;
    conf_data_req = 1'b1; conf_data_wr = 1'b0; conf_data_size = 2'd2; conf_data_addr = 32'h100;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 100; i++) begin @(negedge clk); #1; if (n_addr_ok > a0 + k) break; end
      if (n_addr_ok <= a0 + k) to = 1'b1;
      @(posedge clk); #1;
      if (k < 2) begin
        conf_data_wr = kwr[k]; conf_data_addr = 32'h104 + 32'(4 * k); conf_data_wdata = 32'h5A5A_0000 + k;
      end else conf_data_req = 1'b0;
    end
    for (int i = 0; i < 100; i++) begin @(negedge clk); #1; if (n_data_ok >= d0 + 3) break; end
    repeat (4) @(negedge clk);
    #1;
    exp_rdata = 32'hCAFE_0001;
    n_checks++; if (to || n_data_ok - d0 != 3) begin n_fail++; $display("FAIL b2b_completions: got %0d required 3", n_data_ok - d0); end
    n_checks++; if (n_addr_ok - a0 != 3) begin n_fail++; $display("FAIL b2b_addr_ok_count: got %0d required 3", n_addr_ok - a0); end
    for (int k = 1; k < 3; k++) begin
      if (addr_ok_cyc.size() > a0 + k && dok_cyc.size() > d0 + k - 1) begin
        n_checks++; if (addr_ok_cyc[a0 + k] != dok_cyc[d0 + k - 1]) begin n_fail++; $display("FAIL b2b_no_bubble%0d: got addr_ok cycle %0d required %0d", k, addr_ok_cyc[a0 + k], dok_cyc[d0 + k - 1]); end
      end
    end
    n_checks++; if (n_ar - ar0 != 2 || n_aw - aw0 != 1 || n_w - w0 != 1) begin n_fail++; $display("FAIL b2b_beats: got ar %0d aw %0d w %0d required 2 1 1", n_ar - ar0, n_aw - aw0, n_w - w0); end
  endtask

  task automatic test_reset_mid();
    bit to; int d0, r0;
    d0 = n_data_ok; r0 = n_r;
    ar_delay = 0; r_delay = 8; r_data_cfg = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    conf_data_req = 1'b1; conf_data_wr = 1'b0; conf_data_size = 2'd2; conf_data_addr = 32'h200;
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin @(negedge clk); #1; if (rready) begin to = 1'b0; break; end end
    conf_data_req = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1; #1;
    exp_rdata = 32'd0;
    n_checks++; if (to || {arvalid, rready, conf_data_data_ok} !== 3'b000) begin n_fail++; $display("FAIL rstmid_outputs: got ar %b r %b dok %b required 000", arvalid, rready, conf_data_data_ok); end
    n_checks++; if (conf_data_rdata !== 32'd0) begin n_fail++; $display("FAIL rstmid_rdata: got %h required 00000000", conf_data_rdata); end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    n_checks++; if (n_data_ok != d0 || n_r != r0) begin n_fail++; $display("FAIL rstmid_abandon: got dok %0d r %0d required 0 0", n_data_ok - d0, n_r - r0); end
    r_delay = 0; r_data_cfg = 32'h0BAD_F00D;
    drive_txn(1'b0, 2'd2, 32'h204, 32'h0, to);
    exp_rdata = 32'h0BAD_F00D;
    n_checks++; if (to || last_dok_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rstmid_recover: got %h required 0badf00d", last_dok_rdata); end
  endtask

  task automatic test_random();
    bit to; int a0, d0, ar0, aw0, w0;
    logic wr; logic [1:0] sz; logic [31:0] a, wd; int esz;
    for (int t = 0; t < 24; t++) begin
      wr = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3));
      a = $urandom; wd = $urandom; r_data_cfg = $urandom;
      ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
      esz = (sz == 2'd3) ? 2 : int'(sz);
      a0 = n_addr_ok; d0 = n_data_ok; ar0 = n_ar; aw0 = n_aw; w0 = n_w;
      drive_txn(wr, sz, a, wd, to);
      if (!wr) exp_rdata = r_data_cfg;
      n_checks++; if (to || n_addr_ok - a0 != 1 || n_data_ok - d0 != 1) begin n_fail++; $display("FAIL rand%0d_handshakes: got addr_ok %0d data_ok %0d required 1 1", t, n_addr_ok - a0, n_data_ok - d0); end
      n_checks++; if (n_ar - ar0 != (wr ? 0 : 1) || n_aw - aw0 != (wr ? 1 : 0) || n_w - w0 != (wr ? 1 : 0)) begin n_fail++; $display("FAIL rand%0d_beats: got ar %0d aw %0d w %0d for wr %b", t, n_ar - ar0, n_aw - aw0, n_w - w0, wr); end
      if (wr) begin
        n_checks++; if (cap_awaddr !== a || cap_awsize !== 3'(esz) || cap_wdata !== wd || cap_wstrb !== model_strb(int'(sz), a)) begin n_fail++; $display("FAIL rand%0d_write: got %h sz %0d %h strb %b required %h sz %0d %h strb %b", t, cap_awaddr, cap_awsize, cap_wdata, cap_wstrb, a, esz, wd, model_strb(int'(sz), a)); end
        n_checks++; if (dok_cyc[$] != b_cyc + 1) begin n_fail++; $display("FAIL rand%0d_b_timing: got %0d required %0d", t, dok_cyc[$], b_cyc + 1); end
      end else begin
        n_checks++; if (cap_araddr !== a || cap_arsize !== 3'(esz) || last_dok_rdata !== r_data_cfg) begin n_fail++; $display("FAIL rand%0d_read: got %h sz %0d data %h required %h sz %0d data %h", t, cap_araddr, cap_arsize, last_dok_rdata, a, esz, r_data_cfg); end
        n_checks++; if (dok_cyc[$] != r_cyc + 1) begin n_fail++; $display("FAIL rand%0d_r_timing: got %0d required %0d", t, dok_cyc[$], r_cyc + 1); end
      end
      n_checks++; if (conf_data_rdata !== exp_rdata) begin n_fail++; $display("FAIL rand%0d_rdata_hold: got %h required %h", t, conf_data_rdata, exp_rdata); end
    end
  endtask

`ifdef CONF_AXI_ERR_EN
  task automatic test_err();
    bit to;
    b_resp_cfg = 2'b10; aw_delay = 0; w_delay = 0; b_delay = 1;
    drive_txn(1'b1, 2'd2, 32'h300, 32'h1, to);
    n_checks++; if (to || last_err !== 1'b1) begin n_fail++; $display("FAIL err_bresp_slverr: got %b required 1", last_err); end
    b_resp_cfg = 2'b00; r_resp_cfg = 2'b00; r_data_cfg = 32'h77;
    drive_txn(1'b0, 2'd2, 32'h304, 32'h0, to);
    exp_rdata = 32'h77;
    n_checks++; if (to || last_err !== 1'b0) begin n_fail++; $display("FAIL err_rresp_okay: got %b required 0", last_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_byte_write();
    test_write_order();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef CONF_AXI_ERR_EN
    test_err();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conf_sram2axi.md
CONF_SRAM2AXI -- requirements
Module: conf_sram2axi

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'd1, giving the ID driven on arid/awid.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports conf_data_req/wr  in  1/1  request valid and write flag from the uncached path.
REQ-005 SHALL have ports conf_data_size/addr/wdata  in  2/32/32  byte-count code (0=1B, 1=2B, 2=4B), address and write data.
REQ-006 SHALL have ports conf_data_rdata/addr_ok/data_ok  out  32/1/1  read data, request-accepted pulse and completion pulse.
REQ-007 SHALL have ports arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/8/3/2/1  AXI4 read-address channel.
REQ-008 SHALL have ports arready, rid, rdata, rresp, rlast, rvalid  in  1/4/32/2/1/1, and rready  out  1  AXI4 read-data channel.
REQ-009 SHALL have ports awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/8/3/2/1, and awready  in  1  AXI4 write-address channel.
REQ-010 SHALL have ports wdata/wstrb/wlast/wvalid  out  32/4/1/1, and wready  in  1  AXI4 write-data channel.
REQ-011 SHALL have ports bid/bresp/bvalid  in  4/2/1, and bready  out  1  AXI4 write-response channel.

Function
REQ-012 SHALL allow at most one outstanding transaction; FSM states IDLE, RD_AR, RD_R, WR_AWW, WR_B.
REQ-013 In IDLE with conf_data_req=1, SHALL assert addr_ok combinationally that cycle, latch wr/size/addr/wdata, and go to RD_AR (wr=0) or WR_AWW (wr=1).
REQ-014 addr_ok SHALL be 0 in every state other than IDLE.
REQ-015 RD_AR SHALL hold arvalid=1 with latched values until arready; then go to RD_R.
REQ-016 RD_R SHALL hold rready=1; on rvalid SHALL register rdata into conf_data_rdata, pulse data_ok for exactly one cycle on the next cycle, and return to IDLE.
REQ-017 WR_AWW SHALL raise awvalid and wvalid together, drop each independently on its own handshake, and go to WR_B when both handshakes are done, including when both occur in the same cycle.
REQ-018 WR_B SHALL hold bready=1; on bvalid SHALL pulse data_ok for one cycle on the next cycle and return to IDLE.
REQ-019 A new request SHALL be accepted in the same cycle that data_ok is high (back-to-back, no bubble).
REQ-020 arlen/awlen SHALL be 0, arburst/awburst SHALL be INCR (2'b01), wlast SHALL be 1, and arsize/awsize SHALL be {1'b0,size}.
REQ-021 wstrb SHALL be: size 0 -> 4'b0001<<addr[1:0]; size 1 -> 4'b0011<<{addr[1],1'b0}; size 2 -> 4'b1111. wdata SHALL be passed unshifted.
REQ-022 size 3 SHALL be treated as size 2.
REQ-023 conf_data_rdata SHALL hold its value until the next read completes.
REQ-024 rresp, bresp, rid and bid SHALL be ignored unless REQ-030 applies.

Reset
REQ-025 While rst=1, the FSM SHALL be in IDLE, all AXI valid/ready outputs SHALL be 0, data_ok SHALL be 0 and conf_data_rdata SHALL be 0.
REQ-026 addr_ok SHALL be 0 while rst=1.
REQ-027 Reset mid-transaction SHALL abandon the transaction with no data_ok.

Configuration
REQ-028 Macro CONF_AXI_ERR_EN SHALL gate the error-report feature.
REQ-029 Without CONF_AXI_ERR_EN, the port set SHALL be exactly as listed in REQ-002..REQ-011.
REQ-030 With CONF_AXI_ERR_EN, SHALL add port conf_data_err  out  1, pulsed together with data_ok when the completing rresp/bresp is SLVERR or DECERR (resp[1]=1); reset value 0.

Structure
REQ-031 Shared package SHALL hold the FSM state enum, AXI burst/resp constants (INCR, OKAY, SLVERR, DECERR) and the size-to-wstrb function.
REQ-032 No sub-module; single flat module.

Verification
REQ-033 Read: req=1, wr=0, addr=0x1FD0_F000, size=2; arready delayed 3 cycles; rdata=0xDEAD_BEEF -> one addr_ok, araddr=0x1FD0_F000, arsize=2, one data_ok with rdata=0xDEAD_BEEF.
REQ-034 Byte write: addr=0x1FD0_F003, size=0, wdata=0x0000_00AA -> wstrb=4'b1000, awlen=0, wlast=1, data_ok one cycle after bvalid.
REQ-035 Write with wready 2 cycles before awready, then one with both in the same cycle -> both reach WR_B, exactly one AW and one W beat each.
REQ-036 Back-to-back read, write and read with req held high -> each next addr_ok coincides with the previous data_ok; no extra AXI beats.
REQ-037 rst asserted during RD_R -> arvalid/rready/data_ok 0 immediately; no data_ok for the abandoned read; the next request completes normally.
REQ-038 With CONF_AXI_ERR_EN, bresp=2'b10 -> conf_data_err=1 in the data_ok cycle; with rresp=2'b00 -> conf_data_err=0.
